// File: rtl/bcd_operand_encoder.sv
// Iterative double-dabble binary-to-BCD encoder with start/ready input and valid/ack output handshakes.
// Optional saturation of overflowing results to all-nines: define BCD_OPERAND_SAT_EN.
module bcd_operand_encoder #(
    parameter int N = 3,
    parameter int W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Start_in,
    input  logic [W-1:0]   Bin_in,
    output logic           Ready_out,
    output logic [4*N-1:0] Bcd_out,
    output logic           Ovf_out,
    output logic           Valid_out,
    input  logic           Ack_in
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   bin_q;
    logic [4*N-1:0] work_q;
    logic           ovf_q;
    logic [CW-1:0]  cnt_q;
    logic [4*N-1:0] bcd_q;
    logic           bcd_ovf_q;
    logic           valid_q;

    logic [4*N-1:0] adj;
    logic [4*N-1:0] work_d;
    logic [W-1:0]   bin_d;
    logic           ovf_d;
    logic [4*N-1:0] result_d;

    // One double-dabble step: add-3 per digit, then shift {work, bin} left by one.
    always_comb begin
        adj = work_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        work_d = {adj[4*N-2:0], bin_q[W-1]};
        bin_d  = bin_q << 1;
        ovf_d  = ovf_q | adj[4*N-1];
`ifdef BCD_OPERAND_SAT_EN
        result_d = ovf_d ? {N{4'h9}} : work_d;
`else
        result_d = work_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            work_q    <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            bcd_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start_in) begin
                        bin_q   <= Bin_in;
                        work_q  <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= CW'(W);
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bin_q  <= bin_d;
                    work_q <= work_d;
                    ovf_q  <= ovf_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        bcd_q     <= result_d;
                        bcd_ovf_q <= ovf_d;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (Ack_in) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ready_out = (state_q == IDLE);
    assign Bcd_out   = bcd_q;
    assign Ovf_out   = bcd_ovf_q;
    assign Valid_out = valid_q;

endmodule

// File: tb/tb_bcd_operand_encoder.sv
// Scoreboard bench for bcd_operand_encoder: stimulus pushes expected results, a monitor pops on each new valid.
module tb_bcd_operand_encoder;

    localparam int N = 3;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           Start_in = 1'b0;
    logic [W-1:0]   Bin_in = '0;
    logic           Ready_out;
    logic [4*N-1:0] Bcd_out;
    logic           Ovf_out;
    logic           Valid_out;
    logic           Ack_in = 1'b0;

    int passed = 0;
    int total  = 0;

    logic [4*N:0] exp_q[$];
    logic         vprev = 1'b0;

    bcd_operand_encoder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start_in  (Start_in),
        .Bin_in    (Bin_in),
        .Ready_out (Ready_out),
        .Bcd_out   (Bcd_out),
        .Ovf_out   (Ovf_out),
        .Valid_out (Valid_out),
        .Ack_in    (Ack_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    // Monitor: compares on each rising edge of Valid_out.
    always @(negedge clk) begin
        if (Valid_out && !vprev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(Valid_out), 32'd0);
            end else begin
                logic [4*N:0] e;
                e = exp_q.pop_front();
                chk("bcd", 32'(Bcd_out), 32'(e[4*N-1:0]));
                chk("ovf", 32'(Ovf_out), 32'(e[4*N]));
            end
        end
        vprev <= Valid_out;
    end

    logic [4*N-1:0] last_bcd;

    task automatic do_conv(input logic [W-1:0] bin, input logic [4*N-1:0] exp_bcd,
                           input logic exp_ovf, input int unsigned hold, input bit poke);
        int unsigned lat;
        logic [4*N-1:0] held;
        exp_q.push_back({exp_ovf, exp_bcd});
        @(negedge clk);
        chk("ready_idle", 32'(Ready_out), 32'd1);
        Start_in = 1'b1;
        Bin_in   = bin;
        @(negedge clk);
        Start_in = 1'b0;
        Bin_in   = '0;
        lat = 0;
        while (!Valid_out && lat < W + 5) begin
            if (Ready_out !== 1'b0) chk("ready_conv", 32'(Ready_out), 32'd0);
            Start_in = poke & lat[0];
            Bin_in   = W'(lat);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, W);
        held = Bcd_out;
        last_bcd = Bcd_out;
        for (int unsigned h = 0; h < hold; h++) begin
            Start_in = poke;
            @(negedge clk);
            chk("hold_valid", 32'(Valid_out), 32'd1);
            chk("hold_bcd", 32'(Bcd_out), 32'(held));
            chk("hold_ready", 32'(Ready_out), 32'd0);
        end
        Ack_in   = 1'b1;
        Start_in = poke;
        @(negedge clk);
        Ack_in   = 1'b0;
        Start_in = 1'b0;
        chk("ack_valid", 32'(Valid_out), 32'd0);
        chk("ack_bcd_held", 32'(Bcd_out), 32'(held));
        if (poke) begin
            repeat (W + 2) @(negedge clk);
            chk("no_second_result", 32'(Valid_out), 32'd0);
            chk("ready_after", 32'(Ready_out), 32'd1);
        end
    endtask

    function automatic logic [4*N:0] bcd_add(input logic [4*N-1:0] a, input logic [4*N-1:0] b);
        logic [4*N-1:0] s;
        int unsigned c, d;
        c = 0;
        s = '0;
        for (int unsigned i = 0; i < N; i++) begin
            d = 32'(a[4*i +: 4]) + 32'(b[4*i +: 4]) + c;
            c = (d > 9) ? 1 : 0;
            s[4*i +: 4] = 4'(c ? d - 10 : d);
        end
        return {c[0], s};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4*N-1:0] a123;
        logic [4*N:0]   sum;
        #1;
        chk("rst_ready", 32'(Ready_out), 32'd1);
        chk("rst_valid", 32'(Valid_out), 32'd0);
        chk("rst_bcd", 32'(Bcd_out), 32'd0);
        chk("rst_ovf", 32'(Ovf_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_conv(10'd0,   12'h000, 1'b0, 0, 1'b0);
        do_conv(10'd999, 12'h999, 1'b0, 0, 1'b0);
        do_conv(10'd387, 12'h387, 1'b0, 5, 1'b1);
`ifdef BCD_OPERAND_SAT_EN
        do_conv(10'd1023, 12'h999, 1'b1, 0, 1'b0);
        do_conv(10'd1000, 12'h999, 1'b1, 1, 1'b0);
`else
        do_conv(10'd1023, 12'h023, 1'b1, 0, 1'b0);
        do_conv(10'd1000, 12'h000, 1'b1, 1, 1'b0);
`endif
        do_conv(10'd5,   12'h005, 1'b0, 0, 1'b0);
        do_conv(10'd10,  12'h010, 1'b0, 2, 1'b0);

        // Abort a conversion of 512 with an asynchronous reset mid-cycle.
        @(negedge clk);
        Start_in = 1'b1;
        Bin_in   = 10'd512;
        @(negedge clk);
        Start_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", 32'(Ready_out), 32'd1);
        chk("abort_valid", 32'(Valid_out), 32'd0);
        chk("abort_bcd", 32'(Bcd_out), 32'd0);
        chk("abort_ovf", 32'(Ovf_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("abort_no_result", 32'(Valid_out), 32'd0);
        do_conv(10'd512, 12'h512, 1'b0, 0, 1'b0);

        do_conv(10'd123, 12'h123, 1'b0, 0, 1'b0);
        a123 = last_bcd;
        do_conv(10'd877, 12'h877, 1'b0, 0, 1'b0);
        sum = bcd_add(a123, last_bcd);
        chk("adder_sum", 32'(sum[4*N-1:0]), 32'h000);
        chk("adder_cout", 32'(sum[4*N]), 32'd1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
